// File: rtl/scrambler_lanes_if.sv
// Lane bus for scrambler_lanes: per-lane valid/data in and out, plus the
// shared bypass and seed-load controls.
interface scrambler_lanes_if #(
    parameter int LEN    = 64,
    parameter int LANE_N = 4
);
    logic [LANE_N-1:0]     valid_i;
    logic [LANE_N*LEN-1:0] data_i;
    logic                  bypass_i;
    logic                  seed_v_i;
    logic [57:0]           seed_i;
    logic [LANE_N-1:0]     valid_o;
    logic [LANE_N*LEN-1:0] data_o;

    modport master (
        output valid_i, data_i, bypass_i, seed_v_i, seed_i,
        input  valid_o, data_o
    );

    modport slave (
        input  valid_i, data_i, bypass_i, seed_v_i, seed_i,
        output valid_o, data_o
    );
endinterface

// File: rtl/scrambler_lanes.sv
// Multi-lane 64b/66b self-synchronous scrambler / descrambler,
// G(x) = 1 + x^39 + x^58. Each lane is an independent scrambler_lane.
// Wire order: bit 0 of a lane word is the first bit transmitted.

module scrambler_lane #(
    parameter int          LEN      = 64,
    parameter bit          RX       = 1'b0,
    parameter bit          REG_OUT  = 1'b1,
    parameter logic [57:0] RST_SEED = 58'h0
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           valid_i,
    input  logic [LEN-1:0] data_i,
    input  logic           bypass_i,
    input  logic           seed_v_i,
    input  logic [57:0]    seed_i,
    output logic           valid_o,
    output logic [LEN-1:0] data_o
);
    // One word step. x is the scrambled-side stream in time order:
    // x[57:0] is the history (x[57] = newest = S[0]), x[58+i] is bit i of
    // this word. Taps w(i-39) and w(i-58) are then x[i+19] and x[i], so
    // in-word feedback for LEN > 39 falls out of the unrolled loop.
    // Returns {next state, transformed word}.
    function automatic logic [LEN+57:0] step(input logic [LEN-1:0] d,
                                             input logic [57:0]    s);
        logic [LEN+57:0] x;
        logic [LEN-1:0]  o;
        logic [57:0]     sn;
        x  = '0;
        o  = '0;
        sn = '0;
        for (int m = 0; m < 58; m++) x[m] = s[57-m];
        for (int i = 0; i < LEN; i++) begin
            o[i]     = d[i] ^ x[i+19] ^ x[i];
            // TX feeds back what it puts on the wire, RX what it receives
            x[58+i]  = RX ? d[i] : o[i];
        end
        // newest 58 stream bits become the state, S[0] = newest
        for (int j = 0; j < 58; j++) sn[j] = x[LEN+57-j];
        return {sn, o};
    endfunction

    logic [57:0]    s_q, s_d, s_nxt;
    logic [LEN-1:0] scr, out_c;

    // Transform the word; seed load beats the valid-driven state update,
    // while the output of this cycle still uses the pre-load state.
    always_comb begin
        {s_nxt, scr} = step(data_i, s_q);
        out_c = bypass_i ? data_i : scr;
        s_d   = s_q;
        if (seed_v_i)     s_d = seed_i;
        else if (valid_i) s_d = s_nxt;
    end

    // Lane state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) s_q <= RST_SEED;
        else         s_q <= s_d;
    end

    if (REG_OUT) begin : g_reg_out
        logic           vld_q, vld_d;
        logic [LEN-1:0] dat_q, dat_d;

        // Output data only advances on valid beats so it holds between them
        always_comb begin
            vld_d = valid_i;
            dat_d = valid_i ? out_c : dat_q;
        end

        // Registered output stage, one cycle of latency
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign valid_o = vld_q;
        assign data_o  = dat_q;
    end else begin : g_comb_out
        assign valid_o = valid_i;
        assign data_o  = out_c;
    end
endmodule

module scrambler_lanes #(
    parameter int          LEN      = 64,
    parameter int          LANE_N   = 4,
    parameter bit          RX       = 1'b0,
    parameter bit          REG_OUT  = 1'b1,
    parameter logic [57:0] RST_SEED = 58'h0
) (
    input  logic              clk,
    input  logic              nreset,
    scrambler_lanes_if.slave  bus
);
    // Lanes share only the bypass and seed controls
    for (genvar k = 0; k < LANE_N; k++) begin : g_lane
        scrambler_lane #(
            .LEN      (LEN),
            .RX       (RX),
            .REG_OUT  (REG_OUT),
            .RST_SEED (RST_SEED)
        ) u_lane (
            .clk      (clk),
            .nreset   (nreset),
            .valid_i  (bus.valid_i[k]),
            .data_i   (bus.data_i[k*LEN +: LEN]),
            .bypass_i (bus.bypass_i),
            .seed_v_i (bus.seed_v_i),
            .seed_i   (bus.seed_i),
            .valid_o  (bus.valid_o[k]),
            .data_o   (bus.data_o[k*LEN +: LEN])
        );
    end
endmodule

// File: doc/scrambler_lanes.md
Name: scrambler_lanes

Overview:
- Parametrised multi-lane successor to the single-lane 64b/66b self-synchronous scrambler/descrambler pair.
- Each of LANE_N lanes scrambles (TX) or descrambles (RX) LEN payload bits per cycle with the IEEE 802.3 clause 49 polynomial G(x) = 1 + x^39 + x^58.
- Adds per-lane valid, a runtime bypass, synchronous seed load and an optional registered output stage.
- Sits between the 64b/66b encoder/gearbox and the PMA in TX, and the mirror position in RX.

Parameters:
- LEN, 64, payload bits per lane per cycle; legal 1..128.
- LANE_N, 4, number of independent lanes.
- RX, 0, 0 = scramble, 1 = descramble.
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = combinational from inputs, state still registered.
- RST_SEED, 58'h0, per-lane state value on reset.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- valid_i  in  LANE_N  per-lane data valid.
- data_i  in  LANE_N*LEN  lane k at bits [k*LEN +: LEN]; bit 0 is the first bit on the wire.
- bypass_i  in  1  1 = data passes unmodified, while state still updates.
- seed_v_i  in  1  load seed_i into every lane state.
- seed_i  in  58  seed value.
- valid_o  out  LANE_N  per-lane output valid.
- data_o  out  LANE_N*LEN  scrambled or descrambled data.

Behaviour:
- Per-lane state S[57:0]. S[0] is the most recent wire-side (scrambled) bit; S[j] is the bit j+1 positions earlier.
- TX, per bit i in order 0..LEN-1: o_i = d_i ^ w_(i-39) ^ w_(i-58), where w is the scrambled stream.
  - Terms with negative in-word index come from S.
  - Terms within the current word use the already-computed o bits. The logic fully unrolls for LEN > 39 and LEN > 58.
- RX: o_i = w_i ^ w_(i-39) ^ w_(i-58), where w is the received input stream.
- State update when valid_i[k] = 1: S shifts by LEN and absorbs the scrambled bits of that word (TX: o; RX: data_i).
  - For LEN >= 58, S becomes the last 58 scrambled bits of the word.
  - When valid_i[k] = 0, lane k state holds.
- bypass_i = 1: data_o = data_i. The state still updates from the scrambled-side stream it would have used: TX uses the computed o, RX uses data_i. Lock is therefore preserved when bypass deasserts.
- seed_v_i = 1: every lane S <= seed_i on that edge, which overrides the valid_i update. The data output that cycle still uses the pre-load S.
- REG_OUT = 1:
  - data_o and valid_o are flops updated every edge; valid_o <= valid_i.
  - data_o is loaded only when the lane is valid, otherwise it holds.
  - Latency is exactly 1 cycle.
- REG_OUT = 0: data_o is combinational from data_i and the current S; valid_o = valid_i.
- Reset (asynchronous assert, synchronous release): all S = RST_SEED, valid_o = 0, data_o = 0. A reset mid-stream discards state; the RX side resynchronises after 58 received bits.
- Lanes are fully independent; there is no cross-lane bit interaction.
- Simultaneous seed_v_i and valid_i: the seed wins for the state, and the output is computed from the old state.

Test Plan:
- TX vector: LEN=64, LANE_N=1, RX=0, REG_OUT=1, RST_SEED=0. Drive data 64'h1e, valid=1 -> next cycle data_o = 64'h78000f000000001e, valid_o = 1.
- RX vector: same configuration with RX=1. Drive 64'h78000f000000001e -> next cycle data_o = 64'h1e.
- Loopback: TX into RX instance, LEN=40, LANE_N=4. Run 1000 cycles with random data and random per-lane valid -> RX data_o equals TX data_i delayed 2 cycles on every valid beat, in every lane.
- Self-sync: start RX with seed 58'h2aa..a while TX starts at 0 -> RX output mismatches for at most the first 58 bits, then matches exactly.
- Valid gating: in a 4-lane loopback, hold lane 2 valid=0 for 5 cycles mid-stream -> lane 2 resumes with no errors, valid_o[2]=0 for those 5 cycles, other lanes unaffected.
- Bypass and seed: bypass_i=1 for 3 cycles -> data_o equals data_i; after deassert, the loopback is still error-free. Also assert nreset=0 mid-stream -> valid_o and data_o go to 0 immediately.
